chr_buffer_writer: RTL and testbench

Character-buffer writer for the 70×30 text display. It accepts a byte stream over a valid/ready handshake and interprets each byte as a terminal character or control code. It writes glyph codes into the character RAM that the VGA controller scans, tracks the cursor, and scrolls the screen through the ring-buffer start pointers (`base_addr`, `base_addr_y`) that it drives into the VGA controller.

---
 rtl/chr_buffer_writer.sv | 178 +++++++++++++++++
 tb/tb_chr_buffer_writer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chr_buffer_writer.sv
// Character-buffer writer: turns a byte stream into glyph writes, cursor moves and ring-buffer
// scrolling for the text display. Define CHR_BUFFER_WRITER_CLEAR_ON_RESET_EN to blank the RAM
// after reset.
module chr_buffer_writer #(
  parameter int unsigned CHR_COLS = 70,
  parameter int unsigned CHR_ROWS = 30
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [11:0] base_addr,
  output logic [7:0]  base_addr_y,
  output logic [7:0]  cursor_x,
  output logic [7:0]  cursor_y
);

  localparam logic [11:0] Cols    = 12'(CHR_COLS);
  localparam logic [11:0] Total   = 12'(CHR_COLS * CHR_ROWS);
  localparam logic [7:0]  LastCol = 8'(CHR_COLS - 1);
  localparam logic [7:0]  LastRow = 8'(CHR_ROWS - 1);
  localparam logic [7:0]  Blank   = 8'h20;

`ifdef CHR_BUFFER_WRITER_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {StIdle, StClearRow, StClearAll} state_e;
  localparam state_e ResetState = StClearAll;
`else
  typedef enum logic [1:0] {StIdle, StClearRow} state_e;
  localparam state_e ResetState = StIdle;
`endif

  state_e      state_q, state_d;
  logic [7:0]  cursor_x_q, cursor_x_d;
  logic [7:0]  cursor_y_q, cursor_y_d;
  logic [11:0] row_start_q, row_start_d;
  logic [11:0] base_addr_q, base_addr_d;
  logic [7:0]  base_y_q, base_y_d;
  logic [11:0] clr_cnt_q, clr_cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic        accept;
  logic        do_nl;
  logic [11:0] row_next;
  logic [11:0] base_next;
  logic [11:0] row_inc;
  logic [11:0] base_inc;

  assign in_ready = reset && (state_q == StIdle);
  assign accept   = in_valid && in_ready;

  // Ring-buffer advance by one row: compare-and-subtract instead of modulo.
  assign row_inc   = row_start_q + Cols;
  assign base_inc  = base_addr_q + Cols;
  assign row_next  = (row_inc >= Total) ? row_inc - Total : row_inc;
  assign base_next = (base_inc >= Total) ? base_inc - Total : base_inc;

  always_comb begin
    state_d     = state_q;
    cursor_x_d  = cursor_x_q;
    cursor_y_d  = cursor_y_q;
    row_start_d = row_start_q;
    base_addr_d = base_addr_q;
    base_y_d    = base_y_q;
    clr_cnt_d   = clr_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    do_nl       = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_start_q + {4'b0, cursor_x_q};
            wr_data_d = in_data;
            if (cursor_x_q == LastCol) begin
              do_nl = 1'b1;
            end else begin
              cursor_x_d = cursor_x_q + 8'd1;
            end
          end else if (in_data == 8'h0A) begin
            do_nl = 1'b1;
          end else if (in_data == 8'h0D) begin
            cursor_x_d = 8'd0;
          end else if (in_data == 8'h08 && cursor_x_q != 8'd0) begin
            cursor_x_d = cursor_x_q - 8'd1;
            wr_en_d    = 1'b1;
            wr_addr_d  = row_start_q + {4'b0, cursor_x_q - 8'd1};
            wr_data_d  = Blank;
          end
        end

        if (do_nl) begin
          cursor_x_d = 8'd0;
          if (cursor_y_q != LastRow) begin
            cursor_y_d  = cursor_y_q + 8'd1;
            row_start_d = row_next;
          end else begin
            // Old top row becomes the new bottom row and must be blanked.
            row_start_d = base_addr_q;
            base_addr_d = base_next;
            base_y_d    = (base_y_q == LastRow) ? 8'd0 : base_y_q + 8'd1;
            clr_cnt_d   = 12'd0;
            state_d     = StClearRow;
          end
        end
      end

      StClearRow: begin
        wr_en_d   = 1'b1;
        wr_addr_d = row_start_q + clr_cnt_q;
        wr_data_d = Blank;
        if (clr_cnt_q == Cols - 12'd1) begin
          state_d = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + 12'd1;
        end
      end

`ifdef CHR_BUFFER_WRITER_CLEAR_ON_RESET_EN
      StClearAll: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = Blank;
        if (clr_cnt_q == Total - 12'd1) begin
          state_d = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + 12'd1;
        end
      end
`endif

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!reset) begin
      state_q     <= ResetState;
      cursor_x_q  <= 8'd0;
      cursor_y_q  <= 8'd0;
      row_start_q <= 12'd0;
      base_addr_q <= 12'd0;
      base_y_q    <= 8'd0;
      clr_cnt_q   <= 12'd0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= 12'd0;
      wr_data_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      cursor_x_q  <= cursor_x_d;
      cursor_y_q  <= cursor_y_d;
      row_start_q <= row_start_d;
      base_addr_q <= base_addr_d;
      base_y_q    <= base_y_d;
      clr_cnt_q   <= clr_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign base_addr   = base_addr_q;
  assign base_addr_y = base_y_q;
  assign cursor_x    = cursor_x_q;
  assign cursor_y    = cursor_y_q;

endmodule

// File: tb/tb_chr_buffer_writer.sv
// Directed bench for chr_buffer_writer: printables, row wrap, scrolling, control codes and
// reset during a row clear.
module tb_chr_buffer_writer;

  logic        pclk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [11:0] base_addr;
  logic [7:0]  base_addr_y;
  logic [7:0]  cursor_x;
  logic [7:0]  cursor_y;

  int errors = 0;
  int checks = 0;

  chr_buffer_writer dut (
    .pclk       (pclk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .base_addr  (base_addr),
    .base_addr_y(base_addr_y),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Present one byte for a single edge; outputs are sampled 1 time unit after that edge.
  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge pclk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    int n;
    in_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    reset = 1'b1;
`ifdef CHR_BUFFER_WRITER_CLEAR_ON_RESET_EN
    n = 0;
    while (!in_ready && n < 2300) begin
      @(posedge pclk);
      #1;
      n++;
    end
`endif
  endtask

  task automatic test_reset();
    in_data  = 8'h41;
    in_valid = 1'b1;
    reset    = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data} !== 21'd0) begin
      errors++;
      $display("FAIL reset_wr: got en=%0b addr=%0d data=%0h want 0/0/0", wr_en, wr_addr, wr_data);
    end
    checks++;
    if ({base_addr, base_addr_y, cursor_x, cursor_y} !== 36'd0) begin
      errors++;
      $display("FAIL reset_regs: got base=%0d by=%0d x=%0d y=%0d want all 0",
               base_addr, base_addr_y, cursor_x, cursor_y);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: got %0b want 0", in_ready);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    checks++;
`ifdef CHR_BUFFER_WRITER_CLEAR_ON_RESET_EN
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release: got %0b want 0", in_ready);
    end
`else
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_release: got %0b want 1", in_ready);
    end
`endif
  endtask

`ifdef CHR_BUFFER_WRITER_CLEAR_ON_RESET_EN
  task automatic test_clear_on_reset();
    int bad;
    bad      = 0;
    in_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 2100; i++) begin
      @(posedge pclk);
      #1;
      if (wr_en !== 1'b1 || wr_addr !== 12'(i) || wr_data !== 8'h20 ||
          in_ready !== (i == 2099)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_all_seq: got %0d bad cycles want 0", bad);
    end
    checks++;
    if (cursor_x !== 8'd0 || cursor_y !== 8'd0) begin
      errors++;
      $display("FAIL clear_all_cursor: got (%0d,%0d) want (0,0)", cursor_x, cursor_y);
    end
  endtask
`endif

  task automatic test_single_printable();
    do_reset();
    send_byte(8'h41);
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 12'd0, 8'h41}) begin
      errors++;
      $display("FAIL single_write: got en=%0b addr=%0d data=%0h want 1/0/41",
               wr_en, wr_addr, wr_data);
    end
    checks++;
    if (cursor_x !== 8'd1) begin
      errors++;
      $display("FAIL single_cx: got %0d want 1", cursor_x);
    end
    send_byte(8'h42);
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 12'd1, 8'h42}) begin
      errors++;
      $display("FAIL back_to_back: got en=%0b addr=%0d data=%0h want 1/1/42",
               wr_en, wr_addr, wr_data);
    end
    @(posedge pclk);
    #1;
    checks++;
    if (wr_en !== 1'b0) begin
      errors++;
      $display("FAIL wr_en_pulse: got %0b want 0", wr_en);
    end
  endtask

  task automatic test_row_wrap();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 70; i++) begin
      send_byte(8'h61 + 8'(i % 26));
      if (wr_en !== 1'b1 || wr_addr !== 12'(i)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL row_addrs: got %0d bad writes want 0", bad);
    end
    checks++;
    if (wr_addr !== 12'd69 || cursor_x !== 8'd0 || cursor_y !== 8'd1) begin
      errors++;
      $display("FAIL row_wrap: got addr=%0d cursor=(%0d,%0d) want 69 (0,1)",
               wr_addr, cursor_x, cursor_y);
    end
    send_byte(8'h7E);
    checks++;
    if (wr_addr !== 12'd70 || wr_data !== 8'h7E) begin
      errors++;
      $display("FAIL row2_first: got addr=%0d data=%0h want 70/7e", wr_addr, wr_data);
    end
  endtask

  task automatic test_scroll();
    int bad;
    int n;
    do_reset();
    for (int i = 0; i < 29; i++) send_byte(8'h0A);
    checks++;
    if (cursor_y !== 8'd29 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL lf_to_bottom: got y=%0d en=%0b want 29/0", cursor_y, wr_en);
    end
    send_byte(8'h0A);
    checks++;
    if (base_addr !== 12'd70 || base_addr_y !== 8'd1 || cursor_y !== 8'd29 ||
        in_ready !== 1'b0) begin
      errors++;
      $display("FAIL scroll_regs: got base=%0d by=%0d y=%0d rdy=%0b want 70/1/29/0",
               base_addr, base_addr_y, cursor_y, in_ready);
    end
    bad = 0;
    for (int k = 1; k <= 70; k++) begin
      @(posedge pclk);
      #1;
      if (wr_en !== 1'b1 || wr_addr !== 12'(k - 1) || wr_data !== 8'h20 ||
          in_ready !== (k == 70)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL scroll_clear: got %0d bad cycles want 0", bad);
    end
    send_byte(8'h5A);
    checks++;
    if (wr_addr !== 12'd0 || wr_data !== 8'h5A || cursor_x !== 8'd1) begin
      errors++;
      $display("FAIL after_scroll: got addr=%0d data=%0h x=%0d want 0/5a/1",
               wr_addr, wr_data, cursor_x);
    end
    send_byte(8'h0A);
    @(posedge pclk);
    #1;
    checks++;
    if (wr_addr !== 12'd70 || base_addr !== 12'd140 || base_addr_y !== 8'd2) begin
      errors++;
      $display("FAIL scroll2: got addr=%0d base=%0d by=%0d want 70/140/2",
               wr_addr, base_addr, base_addr_y);
    end
    for (int s = 2; s <= 30; s++) begin
      if (s > 2) send_byte(8'h0A);
      n = 0;
      while (!in_ready && n < 200) begin
        @(posedge pclk);
        #1;
        n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL scroll_timeout: got rdy=%0b want 1 at scroll %0d", in_ready, s);
      end
    end
    checks++;
    if (base_addr !== 12'd0 || base_addr_y !== 8'd0) begin
      errors++;
      $display("FAIL scroll_wrap: got base=%0d by=%0d want 0/0", base_addr, base_addr_y);
    end
    // Printable in the last cell of the last row: char write, then clear starts next cycle.
    for (int i = 0; i < 70; i++) send_byte(8'h30);
    checks++;
    if (wr_addr !== 12'd2099 || wr_data !== 8'h30 || base_addr !== 12'd70) begin
      errors++;
      $display("FAIL last_cell: got addr=%0d data=%0h base=%0d want 2099/30/70",
               wr_addr, wr_data, base_addr);
    end
    @(posedge pclk);
    #1;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 12'd0 || wr_data !== 8'h20) begin
      errors++;
      $display("FAIL last_cell_clear: got en=%0b addr=%0d data=%0h want 1/0/20",
               wr_en, wr_addr, wr_data);
    end
    repeat (75) @(posedge pclk);
    #1;
  endtask

  task automatic test_control_codes();
    do_reset();
    send_byte(8'h61);
    send_byte(8'h62);
    send_byte(8'h63);
    send_byte(8'h08);
    checks++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 12'd2, 8'h20} || cursor_x !== 8'd2) begin
      errors++;
      $display("FAIL bs: got en=%0b addr=%0d data=%0h x=%0d want 1/2/20/2",
               wr_en, wr_addr, wr_data, cursor_x);
    end
    send_byte(8'h0D);
    checks++;
    if (wr_en !== 1'b0 || cursor_x !== 8'd0) begin
      errors++;
      $display("FAIL cr: got en=%0b x=%0d want 0/0", wr_en, cursor_x);
    end
    send_byte(8'h08);
    checks++;
    if (wr_en !== 1'b0 || cursor_x !== 8'd0) begin
      errors++;
      $display("FAIL bs_at_0: got en=%0b x=%0d want 0/0", wr_en, cursor_x);
    end
    send_byte(8'h64);
    send_byte(8'h07);
    checks++;
    if (wr_en !== 1'b0 || cursor_x !== 8'd1 || cursor_y !== 8'd0) begin
      errors++;
      $display("FAIL bell: got en=%0b cursor=(%0d,%0d) want 0 (1,0)", wr_en, cursor_x, cursor_y);
    end
  endtask

  task automatic test_reset_mid_clear();
    int seen;
    do_reset();
    for (int i = 0; i < 30; i++) send_byte(8'h0A);
    repeat (9) @(posedge pclk);
    #1;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 12'd8) begin
      errors++;
      $display("FAIL pre_reset_clear: got en=%0b addr=%0d want 1/8", wr_en, wr_addr);
    end
    reset = 1'b0;
    @(posedge pclk);
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data} !== 21'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_wr: got en=%0b addr=%0d data=%0h rdy=%0b want 0/0/0/0",
               wr_en, wr_addr, wr_data, in_ready);
    end
    checks++;
    if ({base_addr, base_addr_y, cursor_x, cursor_y} !== 36'd0) begin
      errors++;
      $display("FAIL mid_reset_regs: got base=%0d by=%0d x=%0d y=%0d want all 0",
               base_addr, base_addr_y, cursor_x, cursor_y);
    end
    reset = 1'b1;
`ifndef CHR_BUFFER_WRITER_CLEAR_ON_RESET_EN
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge pclk);
      #1;
      if (wr_en === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_writes_after_reset: got %0d writes rdy=%0b want 0/1", seen, in_ready);
    end
`endif
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
`ifdef CHR_BUFFER_WRITER_CLEAR_ON_RESET_EN
    test_clear_on_reset();
`endif
    test_single_printable();
    test_row_wrap();
    test_scroll();
    test_control_codes();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
